counter_mod_ud: RTL and testbench

COUNTER_MOD_UD -- requirements
Module: counter_mod_ud

---
 rtl/counter_mod_ud.sv | 77 +++++++
 tb/tb_counter_mod_ud.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_mod_ud.sv
// Prescaled up/down counter with a runtime terminal value, wrap or saturate at the boundaries,
// a one-cycle terminal-count pulse and sticky overflow/underflow flags.
module counter_mod_ud #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Enable,
    input  logic             Up_Down,
    input  logic             Sat_Mode,
    input  logic             Clr_Flags,
    input  logic [WIDTH-1:0] Data_In,
    input  logic [WIDTH-1:0] Limit,
    input  logic [DIV_W-1:0] Div,
    output logic [WIDTH-1:0] Out,
    output logic             TC,
    output logic             Ovf,
    output logic             Udf
);

    logic [DIV_W-1:0] pre;
    logic             step;
    logic             up_evt;
    logic             dn_evt;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] out_nxt;

    // >= rather than == so that shrinking Div below the current phase still produces a step
    assign step = Enable && !Load && (pre >= Div);
    assign dec  = Out - 1'b1;

    always_comb begin
        up_evt  = 1'b0;
        dn_evt  = 1'b0;
        out_nxt = Out;
        if (Load) begin
            out_nxt = (Data_In > Limit) ? Limit : Data_In;
        end else if (step) begin
            if (Up_Down) begin
                if (Out >= Limit) begin
                    up_evt  = 1'b1;
                    out_nxt = Sat_Mode ? Limit : '0;
                end else begin
                    out_nxt = Out + 1'b1;
                end
            end else if (Out == '0) begin
                dn_evt  = 1'b1;
                out_nxt = Sat_Mode ? '0 : Limit;
            end else begin
                out_nxt = (dec > Limit) ? Limit : dec;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pre <= '0;
            Out <= '0;
            TC  <= 1'b0;
            Ovf <= 1'b0;
            Udf <= 1'b0;
        end else begin
            if (Load || step)
                pre <= '0;
            else if (Enable)
                pre <= pre + 1'b1;
            Out <= out_nxt;
            TC  <= up_evt | dn_evt;
            // a setting event wins over a coincident clear
            Ovf <= up_evt | (Ovf & ~Clr_Flags);
            Udf <= dn_evt | (Udf & ~Clr_Flags);
        end
    end

endmodule

// File: tb/tb_counter_mod_ud.sv
// Scoreboard bench for counter_mod_ud: directed scenarios plus random stimulus against
// an arithmetic reference model; a monitor pops expectations after every clock edge.
module tb_counter_mod_ud;
    localparam int WIDTH = 8;
    localparam int DIV_W = 4;

    typedef struct {
        int out;
        int tc;
        int ovf;
        int udf;
    } exp_t;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Load = 1'b0, Enable = 1'b0, Up_Down = 1'b1, Sat_Mode = 1'b0, Clr_Flags = 1'b0;
    logic [WIDTH-1:0] Data_In = '0, Limit = '0;
    logic [DIV_W-1:0] Div = '0;
    logic [WIDTH-1:0] Out;
    logic             TC, Ovf, Udf;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // reference state: count value, enabled cycles since last step, flags
    int m_out = 0, m_cnt = 0, m_ovf = 0, m_udf = 0;

    counter_mod_ud #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .Reset(Reset), .Load(Load), .Enable(Enable), .Up_Down(Up_Down),
        .Sat_Mode(Sat_Mode), .Clr_Flags(Clr_Flags), .Data_In(Data_In), .Limit(Limit),
        .Div(Div), .Out(Out), .TC(TC), .Ovf(Ovf), .Udf(Udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, predict the post-edge state, wait a full cycle.
    task automatic cycle(input int ld, input int en, input int ud, input int sat, input int clr,
                         input int din, input int lim, input int dv);
        exp_t e;
        int ev_up, ev_dn;
        Load = ld[0]; Enable = en[0]; Up_Down = ud[0]; Sat_Mode = sat[0]; Clr_Flags = clr[0];
        Data_In = din[WIDTH-1:0]; Limit = lim[WIDTH-1:0]; Div = dv[DIV_W-1:0];
        ev_up = 0; ev_dn = 0;
        if (ld != 0) begin
            m_out = (din < lim) ? din : lim;
            m_cnt = 0;
        end else if (en != 0) begin
            if (m_cnt >= dv) begin
                m_cnt = 0;
                if (ud != 0) begin
                    if (m_out < lim) m_out = m_out + 1;
                    else begin ev_up = 1; m_out = (sat != 0) ? lim : 0; end
                end else begin
                    if (m_out > 0) m_out = (m_out - 1 < lim) ? m_out - 1 : lim;
                    else begin ev_dn = 1; m_out = (sat != 0) ? 0 : lim; end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_ovf = (ev_up != 0 || (m_ovf != 0 && clr == 0)) ? 1 : 0;
        m_udf = (ev_dn != 0 || (m_udf != 0 && clr == 0)) ? 1 : 0;
        e.out = m_out; e.tc = ev_up | ev_dn; e.ovf = m_ovf; e.udf = m_udf;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: outputs are presented every cycle; compare whenever an expectation is pending
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Out", int'(Out), e.out);
                check("TC",  int'(TC),  e.tc);
                check("Ovf", int'(Ovf), e.ovf);
                check("Udf", int'(Udf), e.udf);
            end
        end
    end

    initial begin
        #1;
        check("rst_Out", int'(Out), 0);
        check("rst_TC", int'(TC), 0);
        check("rst_Ovf", int'(Ovf), 0);
        check("rst_Udf", int'(Udf), 0);
        #1 Reset = 1'b0;
        @(negedge clk);

        // up, wrap, Div=0, Limit=5: 0..5,0 with TC after 5->0
        for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, 0, 0, 5, 0);
        // load 9 clamps to 5, count down saturating, sitting at 0 pulses TC each step
        cycle(1, 0, 0, 1, 1, 9, 5, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1, 0, 0, 5, 0);
        // Div=3 from 0, then Enable low 2 cycles mid-phase
        cycle(1, 0, 1, 0, 1, 0, 20, 3);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0, 0, 20, 3);
        cycle(0, 1, 1, 0, 0, 0, 20, 3);
        cycle(0, 0, 1, 0, 0, 0, 20, 3);
        cycle(0, 0, 1, 0, 0, 0, 20, 3);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 0, 20, 3);
        // Div shrinks below the current phase: must not wedge
        cycle(0, 1, 1, 0, 0, 0, 20, 9);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 0, 20, 9);
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0, 0, 20, 1);
        // clear coincident with overflow: set wins; clear alone then clears
        cycle(1, 0, 1, 0, 0, 3, 3, 0);
        cycle(0, 1, 1, 0, 1, 0, 3, 0);
        cycle(0, 0, 1, 0, 1, 0, 3, 0);
        // Limit=0: every step is a boundary
        for (int i = 0; i < 3; i++) cycle(0, 1, i % 2, i / 2, 0, 0, 0, 0);
        // load with enable on a step cycle: no increment, no TC, prescaler restarts
        cycle(1, 0, 1, 0, 0, 0, 50, 2);
        cycle(0, 1, 1, 0, 0, 0, 50, 2);
        cycle(0, 1, 1, 0, 0, 0, 50, 2);
        cycle(1, 1, 1, 0, 0, 40, 50, 2);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 50, 2);
        // set Ovf, park at 0x7F, then async reset between edges
        cycle(1, 0, 1, 1, 0, 255, 255, 0);
        cycle(0, 1, 1, 1, 0, 0, 255, 0);
        cycle(1, 0, 1, 0, 0, 127, 255, 0);
        cycle(0, 0, 1, 0, 0, 0, 255, 0);
        #2 Reset = 1'b1;
        #1;
        check("arst_Out", int'(Out), 0);
        check("arst_TC", int'(TC), 0);
        check("arst_Ovf", int'(Ovf), 0);
        check("arst_Udf", int'(Udf), 0);
        @(negedge clk);
        Reset = 1'b0;
        m_out = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, 0, 0, 255, 2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
            cycle(($urandom_range(0, 15) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 255)),
                  lim, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
